// File: rtl/dbuf_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbuf_rx_pkg
// Description : Shared types and parameter checks for digital-buffer receivers.
// Revision    : 1.0 - initial release
// ============================================================================
package dbuf_rx_pkg;

    typedef enum logic [1:0] {
        LO = 2'd0,
        QH = 2'd1,
        HI = 2'd2,
        QL = 2'd3
    } rx_state_t;

    function automatic bit rx_params_ok(int sync_stages, int filt_cycles, int cnt_w);
        return (sync_stages >= 2) && (filt_cycles >= 1) && (cnt_w >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dsync_ff.sv
`default_nettype none
// ============================================================================
// Module      : dsync_ff
// Description : N-stage level synchronizer, asynchronous reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dsync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/dbuf_rx_filt.sv
`default_nettype none
// ============================================================================
// Module      : dbuf_rx_filt
// Description : Synchronize, deglitch and edge-detect an asynchronous level;
//               counts rejected glitches with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module dbuf_rx_filt
    import dbuf_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             SUB,
    input  logic             i,
    input  logic             clr_cnt,
    output logic             o,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam int               c_qw       = $clog2(FILT_CYCLES + 1);
    localparam logic [c_qw-1:0]  c_q_last   = c_qw'(FILT_CYCLES - 1);
    localparam logic [c_qw-1:0]  c_q_one    = c_qw'(1);
    localparam logic [CNT_W-1:0] c_cnt_max  = '1;

    generate
        if (!rx_params_ok(SYNC_STAGES, FILT_CYCLES, CNT_W)) begin : g_bad_params
            $error("dbuf_rx_filt: illegal parameter combination");
        end
    endgenerate

    // Power/ground/substrate pins exist for netlist connectivity only.
    logic w_unused_pins;
    assign w_unused_pins = ^{CELV, CELG, SUB};

    logic w_s;

    dsync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i),
        .q   (w_s)
    );

    rx_state_t        r_state, w_state_nx;
    logic [c_qw-1:0]  r_q, w_q_nx;
    logic             r_o, w_o_nx;
    logic             r_rise, w_rise_nx;
    logic             r_fall, w_fall_nx;
    logic             w_glitch;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LO;
            r_q     <= '0;
            r_o     <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_q     <= w_q_nx;
            r_o     <= w_o_nx;
            r_rise  <= w_rise_nx;
            r_fall  <= w_fall_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_o_nx     = r_o;
        w_rise_nx  = 1'b0;
        w_fall_nx  = 1'b0;
        w_glitch   = 1'b0;
        case (r_state)
            LO: begin
                if (w_s) begin
                    if (FILT_CYCLES == 1) begin
                        w_state_nx = HI;
                        w_o_nx     = 1'b1;
                        w_rise_nx  = 1'b1;
                        w_q_nx     = '0;
                    end else begin
                        w_state_nx = QH;
                        w_q_nx     = c_q_one;
                    end
                end
            end
            QH: begin
                if (w_s) begin
                    if (r_q == c_q_last) begin
                        w_state_nx = HI;
                        w_o_nx     = 1'b1;
                        w_rise_nx  = 1'b1;
                        w_q_nx     = '0;
                    end else begin
                        w_q_nx = r_q + c_q_one;
                    end
                end else begin
                    w_state_nx = LO;
                    w_q_nx     = '0;
                    w_glitch   = 1'b1;
                end
            end
            HI: begin
                if (!w_s) begin
                    if (FILT_CYCLES == 1) begin
                        w_state_nx = LO;
                        w_o_nx     = 1'b0;
                        w_fall_nx  = 1'b1;
                        w_q_nx     = '0;
                    end else begin
                        w_state_nx = QL;
                        w_q_nx     = c_q_one;
                    end
                end
            end
            QL: begin
                if (!w_s) begin
                    if (r_q == c_q_last) begin
                        w_state_nx = LO;
                        w_o_nx     = 1'b0;
                        w_fall_nx  = 1'b1;
                        w_q_nx     = '0;
                    end else begin
                        w_q_nx = r_q + c_q_one;
                    end
                end else begin
                    w_state_nx = HI;
                    w_q_nx     = '0;
                    w_glitch   = 1'b1;
                end
            end
            default: begin
                w_state_nx = LO;
                w_q_nx     = '0;
            end
        endcase
    end

    // Clear wins over a same-cycle rejection; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_glitch && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o          = r_o;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dbuf_rx_filt.sv
`default_nettype none
// ============================================================================
// Module      : tb_dbuf_rx_filt
// Description : Self-checking bench for dbuf_rx_filt (three parameter sets).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dbuf_rx_filt;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] iv  = '0;
    logic [2:0] cl  = '0;

    logic       o0, r0, f0;
    logic [7:0] g0;
    logic       o1, r1, f1;
    logic [1:0] g1;
    logic       o2, r2, f2;
    logic [7:0] g2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dbuf_rx_filt u_def (
        .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .i(iv[0]), .clr_cnt(cl[0]), .o(o0), .rise(r0), .fall(f0), .glitch_cnt(g0)
    );

    dbuf_rx_filt #(.CNT_W(2)) u_c2 (
        .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .i(iv[1]), .clr_cnt(cl[1]), .o(o1), .rise(r1), .fall(f1), .glitch_cnt(g1)
    );

    dbuf_rx_filt #(.FILT_CYCLES(1)) u_f1 (
        .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
        .i(iv[2]), .clr_cnt(cl[2]), .o(o2), .rise(r2), .fall(f2), .glitch_cnt(g2)
    );

    // Reference: delay the input SYNC edges, then accept a new level only after
    // FILT consecutive differing samples; any shorter excursion is a glitch.
    int  filt_k[3] = '{4, 4, 1};
    int  cmax_k[3] = '{255, 3, 255};
    bit  mh[3][SYNC];
    bit  mo[3], mr[3], mf[3];
    int  run[3];
    int  mg[3];
    bit  ms, mrej;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int j = 0; j < SYNC; j++) mh[k][j] = 1'b0;
                mo[k] = 0; mr[k] = 0; mf[k] = 0; run[k] = 0; mg[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                ms = mh[k][SYNC-1];
                for (int j = SYNC-1; j > 0; j--) mh[k][j] = mh[k][j-1];
                mh[k][0] = iv[k];
                mr[k] = 0; mf[k] = 0; mrej = 0;
                if (ms != mo[k]) begin
                    run[k]++;
                    if (run[k] >= filt_k[k]) begin
                        mo[k]  = ms;
                        run[k] = 0;
                        if (ms) mr[k] = 1; else mf[k] = 1;
                    end
                end else begin
                    mrej   = (run[k] > 0);
                    run[k] = 0;
                end
                if (cl[k]) mg[k] = 0;
                else if (mrej && mg[k] < cmax_k[k]) mg[k]++;
            end
        end
    end

    function automatic logic [10:0] act_v(int k);
        case (k)
            0:       return {o0, r0, f0, g0};
            1:       return {o1, r1, f1, 6'd0, g1};
            default: return {o2, r2, f2, g2};
        endcase
    endfunction

    function automatic logic [10:0] exp_v(int k);
        return {mo[k], mr[k], mf[k], 8'(mg[k])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        iv  = '0;
        cl  = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv  = '0;
        #1;
        total++;
        if ({act_v(0), act_v(1), act_v(2)} !== 33'd0) begin
            bad++;
            $display("FAIL reset_values got=%h want=0", {act_v(0), act_v(1), act_v(2)});
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            total++;
            if (act_v(0) !== 11'd0 || exp_v(0) !== 11'd0) begin
                bad++;
                $display("FAIL idle_low cyc=%0d got=%h model=%h want=0", c, act_v(0), exp_v(0));
            end
        end
    endtask

    task automatic test_step();
        logic [10:0] want;
        do_reset();
        iv[0] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            tick();
            want = {(k >= 5) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0, 1'b0, 8'd0};
            total++;
            if (act_v(0) !== want) begin
                bad++;
                $display("FAIL step_latency edge=%0d got=%h want=%h", k, act_v(0), want);
            end
        end
        iv[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (act_v(0) !== exp_v(0)) begin
                bad++;
                $display("FAIL step_fall cyc=%0d got=%h want=%h", c, act_v(0), exp_v(0));
            end
        end
    endtask

    task automatic test_pulses();
        int nr, nf, ohi;
        do_reset();
        for (int w = 3; w <= 4; w++) begin
            nr = 0; nf = 0; ohi = 0;
            for (int c = 0; c < 16; c++) begin
                iv[0] = (c < w);
                tick();
                nr += int'(r0); nf += int'(f0); ohi += int'(o0);
                total++;
                if (act_v(0) !== exp_v(0)) begin
                    bad++;
                    $display("FAIL pulse_model w=%0d cyc=%0d got=%h want=%h", w, c, act_v(0), exp_v(0));
                end
            end
            total++;
            if (nr != (w - 3) || nf != (w - 3) || (ohi != 0) != (w == 4) || g0 !== 8'd1) begin
                bad++;
                $display("FAIL pulse_width w=%0d rises=%0d falls=%0d ohigh=%0d cnt=%0d want_edges=%0d cnt=1",
                         w, nr, nf, ohi, g0, w - 3);
            end
        end
    endtask

    task automatic test_sat();
        int want;
        do_reset();
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 10; c++) begin
                iv[1] = (c < 2);
                cl[1] = (p == 5 && c == 4);
                tick();
                want = (p == 5) ? ((c >= 4) ? 0 : 3)
                                : ((c >= 4) ? ((p + 1 > 3) ? 3 : p + 1) : ((p > 3) ? 3 : p));
                total++;
                if (int'(g1) != want || act_v(1) !== exp_v(1)) begin
                    bad++;
                    $display("FAIL sat_cnt p=%0d cyc=%0d got=%0d want=%0d model=%h", p, c, g1, want, exp_v(1));
                end
            end
        end
        cl[1] = 1'b0;
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            iv[0] = (c < 2);
            tick();
        end
        iv[0] = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        total++;
        if (act_v(0) !== {3'b000, 8'd1}) begin
            bad++;
            $display("FAIL pre_reset got=%h want=%h", act_v(0), {3'b000, 8'd1});
        end
        rst = 1'b1;
        #1;
        total++;
        if (act_v(0) !== 11'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h want=0", act_v(0));
        end
        tick();
        rst = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            total++;
            if (r0 !== (n == 6) || o0 !== (n >= 6) || g0 !== 8'd0 || f0 !== 1'b0) begin
                bad++;
                $display("FAIL post_reset edge=%0d got=%h want_rise=%0d", n, act_v(0), (n == 6));
            end
        end
    endtask

    task automatic test_filt1();
        bit ih[40];
        int nstrobe, ntrans;
        bit want_o;
        do_reset();
        nstrobe = 0;
        for (int c = 0; c < 36; c++) begin
            iv[2] = ((c / 3) % 2 == 1);
            ih[c] = iv[2];
            tick();
            nstrobe += int'(r2) + int'(f2);
            want_o = (c >= 2) ? ih[c-2] : 1'b0;
            total++;
            if (o2 !== want_o || g2 !== 8'd0 || (r2 && f2) || act_v(2) !== exp_v(2)) begin
                bad++;
                $display("FAIL filt1_follow cyc=%0d got=%h want_o=%0d model=%h", c, act_v(2), want_o, exp_v(2));
            end
        end
        ntrans = 0;
        for (int c = 0; c < 34; c++) begin
            if (ih[c] != ((c == 0) ? 1'b0 : ih[c-1])) ntrans++;
        end
        total++;
        if (nstrobe != ntrans) begin
            bad++;
            $display("FAIL filt1_strobes got=%0d want=%0d", nstrobe, ntrans);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 3) == 0) iv[k] = ~iv[k];
                cl[k] = ($urandom_range(0, 49) == 0);
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (act_v(k) !== exp_v(k) || (act_v(k)[9] && act_v(k)[8])) begin
                    bad++;
                    $display("FAIL random inst=%0d cyc=%0d got=%h want=%h", k, c, act_v(k), exp_v(k));
                end
            end
        end
        cl = '0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_pulses();
        test_sat();
        test_rst_mid();
        test_filt1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
